// File: rtl/barcode_frame_parser.sv
// barcode_frame_parser: assembles LF-terminated ASCII barcodes from a UART byte stream and hands each frame off over valid/ready
module barcode_frame_parser #(
  parameter int MAX_LEN = 13,
  parameter int TIMEOUT_CYCLES = 100000,
  localparam int LEN_W = $clog2(MAX_LEN + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_rx_valid,
  output logic [MAX_LEN*8-1:0] o_code_data,
  output logic [LEN_W-1:0]     o_code_len,
  output logic                 o_code_valid,
  input  logic                 i_code_ready,
  output logic                 o_err_overflow,
  output logic                 o_err_char,
  output logic                 o_err_timeout,
  output logic                 o_err_drop
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {S_IDLE, S_RECV, S_DISCARD, S_HOLD} state_t;
  state_t r_state, w_next;
  logic [MAX_LEN*8-1:0] r_buf;
  logic [LEN_W-1:0] r_len;
  logic [TW-1:0] r_cnt;
  logic r_drop, r_ovf, r_chr, r_to, r_drp;
  logic w_print, w_lf, w_ill, w_full, w_idle_hit, w_drop_eff, w_run;
  logic w_start, w_store, w_ovf, w_chr, w_to, w_drp;
  assign w_print = i_rx_data >= 8'h20 && i_rx_data <= 8'h7E;
  assign w_lf = i_rx_data == 8'h0A;
  assign w_ill = !w_print && !w_lf && i_rx_data != 8'h0D;
  assign w_full = r_len == LEN_W'(MAX_LEN);
  assign w_idle_hit = !i_rx_valid && r_cnt == TW'(TIMEOUT_CYCLES - 1);
  // A byte on the handshake cycle itself decides whether the tail of its frame must be discarded
  assign w_drop_eff = i_rx_valid ? !w_lf : r_drop;
  assign w_run = (r_state == S_RECV || r_state == S_DISCARD) && !i_rx_valid && w_next == r_state;
  always_comb begin
    w_next = r_state;
    w_start = 1'b0;
    w_store = 1'b0;
    w_ovf = 1'b0;
    w_chr = 1'b0;
    w_to = 1'b0;
    w_drp = 1'b0;
    case (r_state)
      S_IDLE: if (i_rx_valid) begin
        if (w_print) begin w_start = 1'b1; w_next = S_RECV; end
        else if (w_ill) begin w_chr = 1'b1; w_next = S_DISCARD; end
      end
      S_RECV: if (i_rx_valid) begin
        if (w_print && w_full) begin w_ovf = 1'b1; w_next = S_DISCARD; end
        else if (w_print) w_store = 1'b1;
        else if (w_lf) w_next = S_HOLD;
        else if (w_ill) begin w_chr = 1'b1; w_next = S_DISCARD; end
      end else if (w_idle_hit) begin
        w_to = 1'b1;
        w_next = S_IDLE;
      end
      S_DISCARD: if (i_rx_valid ? w_lf : w_idle_hit) w_next = S_IDLE;
      default: begin
        w_drp = i_rx_valid;
        if (i_code_ready) w_next = w_drop_eff ? S_DISCARD : S_IDLE;
      end
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_buf <= '0;
      r_len <= '0;
      r_cnt <= '0;
      r_drop <= 1'b0;
      r_ovf <= 1'b0;
      r_chr <= 1'b0;
      r_to <= 1'b0;
      r_drp <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt <= !w_run ? '0 : r_cnt == TW'(TIMEOUT_CYCLES) ? r_cnt : r_cnt + 1'b1;
      if (w_start) begin
        r_buf <= (MAX_LEN*8)'(i_rx_data);
        r_len <= LEN_W'(1);
      end else if (w_store) begin
        r_buf[int'(r_len)*8 +: 8] <= i_rx_data;
        r_len <= r_len + 1'b1;
      end
      r_drop <= (r_state == S_HOLD && w_next == S_HOLD) ? w_drop_eff : 1'b0;
      r_ovf <= w_ovf;
      r_chr <= w_chr;
      r_to <= w_to;
      r_drp <= w_drp;
    end
  end
  assign o_code_data = r_buf;
  assign o_code_len = r_len;
  assign o_code_valid = r_state == S_HOLD;
  assign o_err_overflow = r_ovf;
  assign o_err_char = r_chr;
  assign o_err_timeout = r_to;
  assign o_err_drop = r_drp;
endmodule

// File: tb/tb_barcode_frame_parser.sv
// tb_barcode_frame_parser: directed barcode scenarios plus random byte traffic against a queue-based frame model
module tb_barcode_frame_parser;
  localparam int ML = 13, TO = 50, LW = $clog2(ML + 1);
  logic clk = 1'b0, rst, rx_valid = 1'b0, code_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [ML*8-1:0] code_data;
  logic [LW-1:0] code_len;
  logic code_valid, e_ovf, e_chr, e_to, e_drp;
  int total = 0, bad = 0;
  int n_ovf, n_chr, n_to, n_drp, n_val;
  byte unsigned mq[$];
  bit m_frame, m_disc, m_hold, m_pend;
  bit [3:0] m_err;
  int m_idle;
  barcode_frame_parser #(.MAX_LEN(ML), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_code_data(code_data), .o_code_len(code_len), .o_code_valid(code_valid),
    .i_code_ready(code_ready), .o_err_overflow(e_ovf), .o_err_char(e_chr),
    .o_err_timeout(e_to), .o_err_drop(e_drp)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [ML*8-1:0] pack();
    logic [ML*8-1:0] r = '0;
    foreach (mq[i]) r[i*8 +: 8] = mq[i];
    return r;
  endfunction
  task automatic mreset();
    mq.delete();
    m_frame = 0; m_disc = 0; m_hold = 0; m_pend = 0; m_err = '0; m_idle = 0;
  endtask
  task automatic clr();
    n_ovf = 0; n_chr = 0; n_to = 0; n_drp = 0; n_val = 0;
  endtask
  // Frame-level view of the stream: collected chars, whether we are inside/discarding/holding a frame
  task automatic model(bit v, byte unsigned d, bit rdy);
    bit pr = d >= 8'h20 && d <= 8'h7E;
    m_err = '0;
    if (m_hold) begin
      if (v) begin m_err[0] = 1; m_pend = d != 8'h0A; end
      if (rdy) begin m_hold = 0; m_disc = m_pend; m_pend = 0; m_idle = 0; end
    end else if (m_disc) begin
      if (v) begin m_idle = 0; if (d == 8'h0A) m_disc = 0; end
      else if (++m_idle == TO) m_disc = 0;
    end else if (m_frame) begin
      if (v) begin
        m_idle = 0;
        if (pr && mq.size() == ML) begin m_err[3] = 1; m_frame = 0; m_disc = 1; end
        else if (pr) mq.push_back(d);
        else if (d == 8'h0A) begin m_frame = 0; m_hold = 1; end
        else if (d != 8'h0D) begin m_err[2] = 1; m_frame = 0; m_disc = 1; end
      end else if (++m_idle == TO) begin m_err[1] = 1; m_frame = 0; end
    end else if (v) begin
      m_idle = 0;
      if (pr) begin mq = {d}; m_frame = 1; end
      else if (d != 8'h0D && d != 8'h0A) begin m_err[2] = 1; m_disc = 1; end
    end
  endtask
  task automatic step(bit v, byte unsigned d, bit rdy);
    rx_valid = v; rx_data = d; code_ready = rdy;
    model(v, d, rdy);
    @(posedge clk); #1;
    rx_valid = 0; code_ready = 0;
    n_ovf += int'(e_ovf); n_chr += int'(e_chr); n_to += int'(e_to); n_drp += int'(e_drp); n_val += int'(code_valid);
    chk("cycle", {code_valid, code_len, code_data, e_ovf, e_chr, e_to, e_drp},
        {m_hold, LW'(mq.size()), pack(), m_err});
  endtask
  task automatic send(string s, bit rdy = 0);
    for (int i = 0; i < s.len(); i++) step(1, s[i], rdy);
  endtask
  task automatic idle(int n, bit rdy = 0);
    for (int i = 0; i < n; i++) step(0, 8'h00, rdy);
  endtask
  initial begin
    rst = 1;
    mreset(); clr();
    repeat (3) @(posedge clk);
    #1;
    chk("reset", {code_valid, code_len, code_data, e_ovf, e_chr, e_to, e_drp}, '0);
    rst = 0;
    send("4006381333931\r\n");
    chk("t1_len", code_len, 13);
    chk("t1_c0", code_data[7:0], 8'h34);
    chk("t1_c12", code_data[103:96], 8'h31);
    idle(5);
    chk("t1_held", code_valid, 1);
    idle(1, 1);
    chk("t1_released", code_valid, 0);
    clr();
    for (int i = 0; i < 14; i++) step(1, "1", 0);
    send("\n");
    chk("t2_ovf", n_ovf, 1);
    chk("t2_noframe", n_val, 0);
    send("12\n");
    chk("t2_len", code_len, 2);
    chk("t2_data", code_data[15:0], 16'h3231);
    idle(1, 1);
    send("12");
    clr();
    idle(60);
    chk("t3_timeout", n_to, 1);
    chk("t3_noframe", n_val, 0);
    send("7\n");
    chk("t3_data", {code_len, code_data[7:0]}, {4'd1, 8'h37});
    idle(1, 1);
    clr();
    step(1, "1", 0); step(1, 8'h01, 0); send("2\n");
    chk("t4_char", n_chr, 1);
    chk("t4_noframe", n_val, 0);
    send("8\n");
    chk("t4_data", {code_len, code_data[7:0]}, {4'd1, 8'h38});
    idle(1, 1);
    send("1\n");
    clr();
    send("99\n");
    chk("t5_drop", n_drp, 3);
    idle(1, 1);
    send("5\n");
    chk("t5_data", {code_valid, code_data[7:0]}, {1'b1, 8'h35});
    idle(1, 1);
    send("2\n");
    send("99");
    idle(1, 1);
    clr();
    send("3\n");
    chk("t5_eaten", n_val, 0);
    send("4\n");
    chk("t5_data2", {code_valid, code_data[7:0]}, {1'b1, 8'h34});
    idle(1, 1);
    send("123");
    rst = 1;
    #1;
    chk("t6_async", {code_valid, code_len, code_data, e_ovf, e_chr, e_to, e_drp}, '0);
    mreset();
    @(posedge clk); #1;
    rst = 0;
    send("6\n");
    chk("t6_len", code_len, 1);
    idle(1, 1);
    // Random traffic: mostly digits, some terminators, illegal bytes, random ready and long gaps
    for (int it = 0; it < 1500; it++) begin
      int k;
      byte unsigned b;
      if ($urandom_range(0, 99) < 4) idle($urandom_range(40, 70), $urandom_range(0, 3) == 0);
      else begin
        k = $urandom_range(0, 19);
        b = k < 12 ? 8'h30 + 8'(k % 10) : k < 14 ? 8'h0A : k == 14 ? 8'h0D : k == 15 ? 8'h01 :
            k == 16 ? 8'h7F : k == 17 ? 8'h20 : k == 18 ? 8'h7E : 8'($urandom_range(0, 255));
        step($urandom_range(0, 3) != 0, b, $urandom_range(0, 3) == 0);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
